// File: rtl/bp_be_late_wb_queue.sv
// In-order late writeback queue between the memory pipe and the int/FP regfile
// late write ports; exports per-register pending masks for the scheduler.
module bp_be_late_wb_queue #(
  parameter int els_p            = 4,
  parameter int dpath_width_p    = 66,
  parameter int reg_addr_width_p = 5
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,

  input  logic                           in_v_i,
  input  logic                           in_float_i,
  input  logic [reg_addr_width_p-1:0]    in_rd_addr_i,
  input  logic [dpath_width_p-1:0]       in_data_i,
  output logic                           in_yumi_o,

  output logic                           iwb_v_o,
  output logic [reg_addr_width_p-1:0]    iwb_rd_addr_o,
  output logic [dpath_width_p-1:0]       iwb_data_o,
  input  logic                           iwb_yumi_i,

  output logic                           fwb_v_o,
  output logic [reg_addr_width_p-1:0]    fwb_rd_addr_o,
  output logic [dpath_width_p-1:0]       fwb_data_o,
  input  logic                           fwb_yumi_i,

  output logic [2**reg_addr_width_p-1:0] pending_ird_o,
  output logic [2**reg_addr_width_p-1:0] pending_frd_o,
  output logic [$clog2(els_p+1)-1:0]     count_o,
  output logic                           full_o,
  output logic                           empty_o
);

  localparam int ptr_w_lp  = $clog2(els_p);
  localparam int cnt_w_lp  = $clog2(els_p+1);
  localparam int regs_lp   = 2**reg_addr_width_p;

  logic [ptr_w_lp-1:0]         r_rptr;
  logic [ptr_w_lp-1:0]         r_wptr;
  logic [cnt_w_lp-1:0]         r_count;

  logic                        r_float [els_p];
  logic [reg_addr_width_p-1:0] r_rd    [els_p];
  logic [dpath_width_p-1:0]    r_data  [els_p];

  logic                        w_head_float;
  logic [reg_addr_width_p-1:0] w_head_rd;
  logic                        w_head_x0;
  logic                        w_enq;
  logic                        w_deq;
  logic [ptr_w_lp-1:0]         w_offset [els_p];
  logic [regs_lp-1:0]          w_pending_ird;
  logic [regs_lp-1:0]          w_pending_frd;

  assign w_head_float = r_float[r_rptr];
  assign w_head_rd    = r_rd[r_rptr];
  assign w_head_x0    = ~w_head_float & (w_head_rd == '0);

  assign count_o = r_count;
  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == cnt_w_lp'(els_p));

  // Gating with reset keeps the mem pipe from seeing an accept that is being dropped.
  assign w_enq     = in_v_i & ~full_o & reset_n_i;
  assign in_yumi_o = w_enq;

  assign iwb_v_o       = ~empty_o & ~w_head_float & ~w_head_x0;
  assign fwb_v_o       = ~empty_o & w_head_float;
  assign iwb_rd_addr_o = w_head_rd;
  assign fwb_rd_addr_o = w_head_rd;
  assign iwb_data_o    = r_data[r_rptr];
  assign fwb_data_o    = r_data[r_rptr];

  // x0 writes have no architectural effect, so they drain on their own.
  assign w_deq = (iwb_v_o & iwb_yumi_i) | (fwb_v_o & fwb_yumi_i) | (~empty_o & w_head_x0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + ptr_w_lp'(1);
      if (w_deq) r_rptr <= r_rptr + ptr_w_lp'(1);
      if (w_enq && !w_deq)      r_count <= r_count + cnt_w_lp'(1);
      else if (!w_enq && w_deq) r_count <= r_count - cnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_float[r_wptr] <= in_float_i;
      r_rd[r_wptr]    <= in_rd_addr_i;
      r_data[r_wptr]  <= in_data_i;
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    w_pending_ird = '0;
    w_pending_frd = '0;
    for (int i = 0; i < els_p; i++) begin
      w_offset[i] = ptr_w_lp'(i) - r_rptr;
      if (cnt_w_lp'(w_offset[i]) < r_count) begin
        if (r_float[i])
          w_pending_frd[r_rd[i]] = 1'b1;
        else if (r_rd[i] != '0)
          w_pending_ird[r_rd[i]] = 1'b1;
      end
    end
  end

  assign pending_ird_o = w_pending_ird;
  assign pending_frd_o = w_pending_frd;

  yumiWithoutValid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !((iwb_yumi_i & ~empty_o & ~iwb_v_o) | (fwb_yumi_i & ~empty_o & ~fwb_v_o)));

endmodule

// File: tb/tb_bp_be_late_wb_queue.sv
// Randomized and directed bench for bp_be_late_wb_queue, checked against a
// queue-based reference model of the late writeback buffer.
module tb_bp_be_late_wb_queue;

  localparam int ELS  = 4;
  localparam int DW   = 66;
  localparam int AW   = 5;
  localparam int REGS = 2**AW;
  localparam int CW   = $clog2(ELS+1);

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic            in_v_i;
  logic            in_float_i;
  logic [AW-1:0]   in_rd_addr_i;
  logic [DW-1:0]   in_data_i;
  logic            in_yumi_o;
  logic            iwb_v_o;
  logic [AW-1:0]   iwb_rd_addr_o;
  logic [DW-1:0]   iwb_data_o;
  logic            iwb_yumi_i;
  logic            fwb_v_o;
  logic [AW-1:0]   fwb_rd_addr_o;
  logic [DW-1:0]   fwb_data_o;
  logic            fwb_yumi_i;
  logic [REGS-1:0] pending_ird_o;
  logic [REGS-1:0] pending_frd_o;
  logic [CW-1:0]   count_o;
  logic            full_o;
  logic            empty_o;

  bp_be_late_wb_queue #(.els_p(ELS), .dpath_width_p(DW), .reg_addr_width_p(AW)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .in_v_i(in_v_i), .in_float_i(in_float_i), .in_rd_addr_i(in_rd_addr_i),
    .in_data_i(in_data_i), .in_yumi_o(in_yumi_o),
    .iwb_v_o(iwb_v_o), .iwb_rd_addr_o(iwb_rd_addr_o), .iwb_data_o(iwb_data_o),
    .iwb_yumi_i(iwb_yumi_i),
    .fwb_v_o(fwb_v_o), .fwb_rd_addr_o(fwb_rd_addr_o), .fwb_data_o(fwb_data_o),
    .fwb_yumi_i(fwb_yumi_i),
    .pending_ird_o(pending_ird_o), .pending_frd_o(pending_frd_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          isFloat;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  entry_t modelQ[$];
  int     assertCount = 0;
  int     failCount   = 0;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected outputs come straight from the queue contents, not from any pointer state.
  task automatic checkAll(input bit inReset);
    logic [REGS-1:0] expIrd;
    logic [REGS-1:0] expFrd;
    bit              hasHead;
    entry_t          head;
    expIrd  = '0;
    expFrd  = '0;
    hasHead = (modelQ.size() > 0);
    foreach (modelQ[k]) begin
      if (modelQ[k].isFloat) expFrd[modelQ[k].rd] = 1'b1;
      else if (modelQ[k].rd != 0) expIrd[modelQ[k].rd] = 1'b1;
    end
    checkOutput("count", 128'(count_o), 128'(modelQ.size()));
    checkOutput("empty", 128'(empty_o), 128'(modelQ.size() == 0));
    checkOutput("full", 128'(full_o), 128'(modelQ.size() == ELS));
    checkOutput("in_yumi", 128'(in_yumi_o), 128'(!inReset && in_v_i && modelQ.size() < ELS));
    checkOutput("pending_ird", 128'(pending_ird_o), 128'(expIrd));
    checkOutput("pending_frd", 128'(pending_frd_o), 128'(expFrd));
    if (hasHead) begin
      head = modelQ[0];
      checkOutput("iwb_v", 128'(iwb_v_o), 128'(!head.isFloat && head.rd != 0));
      checkOutput("fwb_v", 128'(fwb_v_o), 128'(head.isFloat));
      checkOutput("iwb_rd", 128'(iwb_rd_addr_o), 128'(head.rd));
      checkOutput("iwb_data", 128'(iwb_data_o), 128'(head.data));
      checkOutput("fwb_rd", 128'(fwb_rd_addr_o), 128'(head.rd));
      checkOutput("fwb_data", 128'(fwb_data_o), 128'(head.data));
    end else begin
      checkOutput("iwb_v", 128'(iwb_v_o), 128'(0));
      checkOutput("fwb_v", 128'(fwb_v_o), 128'(0));
    end
  endtask

  // One full cycle starting at a negedge: drive, check, clock, advance the model.
  task automatic applyStimulus(input bit v, input bit f, input logic [AW-1:0] rd,
                               input logic [DW-1:0] d, input bit iy, input bit fy);
    bit     headInt;
    bit     headFp;
    bit     accept;
    bit     drain;
    entry_t e;
    headInt = modelQ.size() > 0 && !modelQ[0].isFloat && modelQ[0].rd != 0;
    headFp  = modelQ.size() > 0 && modelQ[0].isFloat;
    if (modelQ.size() > 0) begin
      iy = iy && headInt;
      fy = fy && headFp;
    end
    in_v_i       = v;
    in_float_i   = f;
    in_rd_addr_i = rd;
    in_data_i    = d;
    iwb_yumi_i   = iy;
    fwb_yumi_i   = fy;
    #1;
    checkAll(1'b0);
    @(posedge clk_i);
    accept = v && modelQ.size() < ELS;
    drain  = modelQ.size() > 0 &&
             ((!modelQ[0].isFloat && modelQ[0].rd == 0) || (headInt && iy) || (headFp && fy));
    if (drain) void'(modelQ.pop_front());
    if (accept) begin
      e.isFloat = f;
      e.rd      = rd;
      e.data    = d;
      modelQ.push_back(e);
    end
    @(negedge clk_i);
  endtask

  task automatic applyReset();
    in_v_i     = 1'b1;
    iwb_yumi_i = 1'b0;
    fwb_yumi_i = 1'b0;
    reset_n_i  = 1'b0;
    modelQ.delete();
    #1;
    checkAll(1'b1);
    @(negedge clk_i);
    #1;
    checkAll(1'b1);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    in_v_i    = 1'b0;
  endtask

  function automatic logic [DW-1:0] randData();
    return DW'({$urandom, $urandom, $urandom});
  endfunction

  initial begin
    reset_n_i    = 1'b0;
    in_v_i       = 1'b0;
    in_float_i   = 1'b0;
    in_rd_addr_i = '0;
    in_data_i    = '0;
    iwb_yumi_i   = 1'b0;
    fwb_yumi_i   = 1'b0;
    @(negedge clk_i);
    applyReset();

    applyStimulus(1, 0, 5, DW'('h1234), 1, 0);
    applyStimulus(0, 0, 0, '0, 1, 0);
    applyStimulus(0, 0, 0, '0, 1, 0);

    applyStimulus(1, 0, 1, DW'('h11), 0, 0);
    applyStimulus(1, 1, 2, DW'('h22), 0, 0);
    applyStimulus(1, 0, 1, DW'('h33), 0, 0);
    applyStimulus(1, 1, 3, DW'('h44), 0, 0);
    applyStimulus(1, 0, 9, DW'('h55), 0, 0);
    applyStimulus(1, 0, 9, DW'('h55), 1, 0);
    applyStimulus(1, 0, 9, DW'('h55), 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, '0, 1, 1);

    applyStimulus(1, 0, 0, DW'('hdead), 1, 1);
    applyStimulus(1, 1, 7, DW'('hf7), 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, '0, 0, 1);

    applyStimulus(1, 1, 4, DW'('hf4), 0, 0);
    applyStimulus(1, 0, 9, DW'('h99), 1, 0);
    applyStimulus(0, 0, 0, '0, 1, 0);
    applyStimulus(0, 0, 0, '0, 1, 0);
    applyStimulus(0, 0, 0, '0, 1, 1);
    applyStimulus(0, 0, 0, '0, 1, 0);
    applyStimulus(0, 0, 0, '0, 1, 0);

    applyStimulus(1, 0, 3, DW'('ha), 0, 0);
    applyStimulus(1, 1, 3, DW'('hb), 0, 0);
    applyStimulus(1, 0, 6, DW'('hc), 0, 0);
    applyReset();
    applyStimulus(1, 1, 8, DW'('hd), 0, 0);
    applyStimulus(0, 0, 0, '0, 0, 1);
    applyStimulus(0, 0, 0, '0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      if (i == 400) applyReset();
      applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                    AW'($urandom_range(0, 7)), randData(),
                    $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 50);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/bp_be_late_wb_queue.md
Name: bp_be_late_wb_queue

Overview:
- In-order buffer between the memory pipe's late writeback outputs (D$ miss/uncached load returns) and the register file late write ports.
- Accepts integer and float late writeback packets and holds them until the integer or float regfile port accepts them.
- Exports per-register pending masks so the scheduler can hold dependent instructions.
- Decouples D$ late-data release from regfile port contention.

Parameters:
- els_p, 4, queue depth in entries (power of two, at least 2)
- dpath_width_p, 66, writeback data width (matches dpath_width_gp)
- reg_addr_width_p, 5, register address width

Ports:
- clk_i  input  1  clock; all state updates on posedge
- reset_n_i  input  1  asynchronous active-low reset
- in_v_i  input  1  late writeback packet valid from mem pipe
- in_float_i  input  1  1 = FP destination, 0 = integer destination
- in_rd_addr_i  input  reg_addr_width_p  destination register
- in_data_i  input  dpath_width_p  writeback data
- in_yumi_o  output  1  packet accepted this cycle
- iwb_v_o  output  1  integer write valid
- iwb_rd_addr_o  output  reg_addr_width_p  integer destination
- iwb_data_o  output  dpath_width_p  integer data
- iwb_yumi_i  input  1  integer port consumed the head entry
- fwb_v_o  output  1  FP write valid
- fwb_rd_addr_o  output  reg_addr_width_p  FP destination
- fwb_data_o  output  dpath_width_p  FP data
- fwb_yumi_i  input  1  FP port consumed the head entry
- pending_ird_o  output  2**reg_addr_width_p  integer registers with a queued write
- pending_frd_o  output  2**reg_addr_width_p  FP registers with a queued write
- count_o  output  $clog2(els_p+1)  current occupancy
- full_o  output  1  count_o == els_p
- empty_o  output  1  count_o == 0

Behaviour:
- Reset (async assert, sync-release safe): read pointer, write pointer and count cleared. All valid outputs, pending masks, in_yumi_o and full_o are 0; empty_o is 1. Entry payload is not reset. Reset mid-operation drops all queued entries immediately.
- Enqueue:
  - in_yumi_o = in_v_i & ~full_o. This is valid-then-yumi; the mem pipe holds the packet until yumi.
  - When full, no enqueue occurs even if a dequeue happens in the same cycle, so there is no yumi-to-yumi combinational path.
  - An accepted entry is written at the write pointer. The pointer wraps modulo els_p.
- Latency: an accepted packet appears at the head no earlier than the next cycle. There is no combinational in-to-out bypass.
- Head presentation: only the head entry drives outputs, which keeps delivery strictly in order across int and FP.
  - iwb_v_o = ~empty & ~head.float & (head.rd_addr != 0).
  - fwb_v_o = ~empty & head.float.
  - Address and data outputs always carry the head payload, whether or not valid is asserted.
- Dequeue:
  - Occurs when (iwb_v_o & iwb_yumi_i) | (fwb_v_o & fwb_yumi_i), or when the head is an integer write to x0.
  - An x0 head self-discards in one cycle without asserting iwb_v_o.
  - A yumi without the matching valid is illegal (assertion). Yumi while empty is ignored.
- Count: +1 on enqueue only, -1 on dequeue only, unchanged when both or neither occur.
- Pending masks: bit r of pending_ird_o is the OR over valid entries of (~float & rd_addr == r & r != 0); pending_frd_o likewise for float entries. Both are combinational from state only.
  - Duplicate destinations in the queue keep the bit set until the last matching entry drains.
  - Bit 0 of pending_ird_o is always 0.
- Ordering: no reordering or coalescing. A stalled FP head blocks later integer entries, and vice versa.

Test Plan:
- Reset with reset_n_i=0 mid-stream holding 3 entries -> same cycle: count_o=0, empty_o=1, iwb_v_o=fwb_v_o=0, masks all 0; after release, the first new packet appears 1 cycle after accept.
- Enqueue int rd=5 data=0x1234 with iwb_yumi_i=1 held -> in_yumi_o=1 at cycle 0; iwb_v_o=1, rd=5, data=0x1234 at cycle 1; pending_ird_o[5]=1 at cycle 1, 0 at cycle 2.
- Fill 4 entries (int r1, fp f2, int r1, fp f3) with no yumis -> full_o=1, in_yumi_o=0 for a 5th valid packet; pending_ird_o[1]=1 until both r1 entries drain; entries exit in order r1, f2, r1, f3.
- Full queue with iwb_yumi_i=1 on the head and in_v_i=1 in the same cycle -> no enqueue, count goes 4->3; enqueue is accepted the following cycle.
- Int rd=0 at head followed by fp f7 -> iwb_v_o never asserted; x0 entry leaves in 1 cycle; fwb_v_o=1 for f7 the next cycle.
- FP head held (fwb_yumi_i=0) with int r9 behind it and iwb_yumi_i=1 -> iwb_v_o stays 0 until the FP entry is consumed; then r9 is delivered the next cycle.
